// File: rtl/clasificador_ctrl.sv
// clasificador_ctrl: sequencer for one coffee-bean sorting lane.
// Feeds a bean, debounces and grades its sensors, pulses the matching
// diverter gate and keeps saturating per-grade counters.
module clasificador_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned GATE_CYCLES   = 8,
  parameter int unsigned TIMEOUT       = 1000,
  parameter int unsigned CW            = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          fault_clr,
  input  logic          clear_counts,
  output logic          feed_req,
  input  logic          feed_ack,
  input  logic          bean_present,
  input  logic          sensor_tamano,
  input  logic          sensor_peso,
  input  logic          sensor_color,
  output logic          gate_baja,
  output logic          gate_media,
  output logic          gate_alta,
  output logic [1:0]    grade,
  output logic          grade_valid,
  output logic          busy,
  output logic          fault,
  output logic [CW-1:0] cnt_baja,
  output logic [CW-1:0] cnt_media,
  output logic [CW-1:0] cnt_alta
);

  localparam int unsigned TMAX = (TIMEOUT > GATE_CYCLES) ? TIMEOUT : GATE_CYCLES;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned SW   = $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] G_BAJA  = 2'b00;
  localparam logic [1:0] G_MEDIA = 2'b01;
  localparam logic [1:0] G_ALTA  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FEED, S_WAIT_BEAN, S_SETTLE, S_ACTUATE, S_CLEAR, S_FAULT
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [SW-1:0] stable, stable_d, stable_run;
  logic [2:0]    triple, prev;
  logic [1:0]    sample_grade, gate_sel;
  logic          latch;

  assign triple = {sensor_tamano, sensor_peso, sensor_color};

  // Grade of the sensor triple currently presented
  always_comb begin
    sample_grade = G_BAJA;
    if (triple == 3'b111)           sample_grade = G_ALTA;
    else if (triple[2:1] == 2'b11)  sample_grade = G_MEDIA;
  end

  // Next state, timer and debounce run length
  always_comb begin
    state_d    = state;
    timer_d    = '0;
    stable_d   = stable;
    latch      = 1'b0;
    // stable == 0 on SETTLE entry, so the first SETTLE cycle always counts as 1
    stable_run = (triple == prev) ? stable + SW'(1) : SW'(1);
    case (state)
      S_IDLE: begin
        if (enable) state_d = S_FEED;
      end
      S_FEED: begin
        if (feed_ack)     state_d = S_WAIT_BEAN;
        else if (!enable) state_d = S_IDLE;
      end
      S_WAIT_BEAN: begin
        if (bean_present) begin
          state_d  = S_SETTLE;
          stable_d = '0;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      S_SETTLE: begin
        if (!bean_present) begin
          state_d = S_WAIT_BEAN;
        end else if (stable_run == SW'(SETTLE_CYCLES)) begin
          state_d = S_ACTUATE;
          latch   = 1'b1;
        end else begin
          stable_d = stable_run;
        end
      end
      S_ACTUATE: begin
        if (timer == TW'(GATE_CYCLES - 1)) state_d = S_CLEAR;
        else                               timer_d = timer + TW'(1);
      end
      S_CLEAR: begin
        if (!bean_present)                      state_d = enable ? S_FEED : S_IDLE;
        else if (timer == TW'(TIMEOUT - 1))     state_d = S_FAULT;
        else                                    timer_d = timer + TW'(1);
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gate follows the grade being latched on the first ACTUATE cycle, then the held grade
  always_comb begin
    gate_sel = latch ? sample_grade : grade;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  // Timer, debounce counter and previous sensor sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer  <= '0;
      stable <= '0;
      prev   <= '0;
    end else begin
      timer  <= timer_d;
      stable <= stable_d;
      if (state == S_SETTLE) prev <= triple;
    end
  end

  // Registered status, strobe and actuator outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_req    <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      grade_valid <= 1'b0;
      grade       <= G_BAJA;
      gate_baja   <= 1'b0;
      gate_media  <= 1'b0;
      gate_alta   <= 1'b0;
    end else begin
      feed_req    <= (state_d == S_FEED);
      busy        <= (state_d != S_IDLE) && (state_d != S_FAULT);
      fault       <= (state_d == S_FAULT);
      grade_valid <= latch;
      if (latch) grade <= sample_grade;
      gate_baja   <= (state_d == S_ACTUATE) && (gate_sel == G_BAJA);
      gate_media  <= (state_d == S_ACTUATE) && (gate_sel == G_MEDIA);
      gate_alta   <= (state_d == S_ACTUATE) && (gate_sel == G_ALTA);
    end
  end

  // Saturating per-grade counters; clear has priority over an increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_baja  <= '0;
      cnt_media <= '0;
      cnt_alta  <= '0;
    end else if (clear_counts) begin
      cnt_baja  <= '0;
      cnt_media <= '0;
      cnt_alta  <= '0;
    end else if (latch) begin
      case (sample_grade)
        G_BAJA:  if (cnt_baja  != '1) cnt_baja  <= cnt_baja  + CW'(1);
        G_MEDIA: if (cnt_media != '1) cnt_media <= cnt_media + CW'(1);
        G_ALTA:  if (cnt_alta  != '1) cnt_alta  <= cnt_alta  + CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clasificador_ctrl.sv
// Self-checking bench for clasificador_ctrl: directed and randomized beans
// compared against a sequence-level reference model.
module tb_clasificador_ctrl;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned GATE   = 8;
  localparam int unsigned TOUT   = 1000;
  localparam int unsigned CW     = 4;
  localparam int          CMAX   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0, fault_clr = 1'b0, clear_counts = 1'b0;
  logic          feed_ack = 1'b0, bean_present = 1'b0;
  logic [2:0]    sens = 3'b000;
  logic          feed_req, gate_baja, gate_media, gate_alta, grade_valid, busy, fault;
  logic [1:0]    grade;
  logic [CW-1:0] cnt_baja, cnt_media, cnt_alta;
  logic [2:0]    gates_obs;

  int         checks = 0;
  int         errors = 0;
  int         exp_cnt[3] = '{0, 0, 0};
  logic [1:0] exp_grade = 2'b00;
  logic [2:0] seq[$];

  assign gates_obs = {gate_alta, gate_media, gate_baja};

  always #5 clk = ~clk;

  clasificador_ctrl #(.SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .TIMEOUT(TOUT), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault_clr(fault_clr),
    .clear_counts(clear_counts), .feed_req(feed_req), .feed_ack(feed_ack),
    .bean_present(bean_present), .sensor_tamano(sens[2]), .sensor_peso(sens[1]),
    .sensor_color(sens[0]), .gate_baja(gate_baja), .gate_media(gate_media),
    .gate_alta(gate_alta), .grade(grade), .grade_valid(grade_valid), .busy(busy),
    .fault(fault), .cnt_baja(cnt_baja), .cnt_media(cnt_media), .cnt_alta(cnt_alta)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grading rule applied to a whole sample
  function automatic logic [1:0] ref_grade(logic [2:0] t);
    if (t == 3'b111) return 2'b10;
    if (t[2:1] == 2'b11) return 2'b01;
    return 2'b00;
  endfunction

  // Index of the sample that completes the first run of SETTLE identical samples
  function automatic int settle_index();
    int run = 0;
    foreach (seq[i]) begin
      run = (i > 0 && seq[i] == seq[i-1]) ? run + 1 : 1;
      if (run >= SETTLE) return i;
    end
    return seq.size() - 1;
  endfunction

  task automatic fill_const(input logic [2:0] v);
    seq.delete();
    repeat (SETTLE) seq.push_back(v);
  endtask

  // One complete bean: feed, wait, debounce, actuate, clear
  task automatic sort_bean(input int ack_delay, input int bean_delay, input bit drop,
                           input bit clr_on_inc, input int rst_at, input bit end_enable);
    int t;
    logic [1:0] g;
    logic [2:0] hot;
    t   = settle_index();
    g   = ref_grade(seq[t]);
    hot = 3'b001 << g;
    enable = 1'b1;
    for (int k = 0; k < 4 && feed_req !== 1'b1; k++) tick();
    checks++;
    if (feed_req !== 1'b1) begin errors++; $display("FAIL feed_req_high: got %b want 1", feed_req); end
    for (int k = 0; k < ack_delay; k++) begin
      tick();
      checks++;
      if (feed_req !== 1'b1) begin errors++; $display("FAIL feed_req_hold: got %b want 1", feed_req); end
    end
    feed_ack = 1'b1;
    tick();
    feed_ack = 1'b0;
    enable = 1'($urandom_range(0, 1));
    checks++;
    if (feed_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL feed_req_drop: feed_req=%b busy=%b want 0/1", feed_req, busy);
    end
    if (drop) begin
      bean_present = 1'b1; sens = 3'($urandom);
      tick(); tick();
      bean_present = 1'b0;
      tick();
      checks++;
      if (grade_valid !== 1'b0 || busy !== 1'b1 || gates_obs !== 3'b000) begin
        errors++; $display("FAIL settle_drop: gv=%b busy=%b gates=%b want 0/1/000", grade_valid, busy, gates_obs);
      end
    end
    for (int k = 0; k < bean_delay; k++) begin
      sens = 3'($urandom);
      tick();
      checks++;
      if (busy !== 1'b1 || fault !== 1'b0 || grade_valid !== 1'b0) begin
        errors++; $display("FAIL wait_bean: busy=%b fault=%b gv=%b want 1/0/0", busy, fault, grade_valid);
      end
    end
    bean_present = 1'b1;
    sens = 3'($urandom);
    tick();
    for (int i = 0; i <= t; i++) begin
      sens = seq[i];
      if (i == t && clr_on_inc) clear_counts = 1'b1;
      tick();
      checks++;
      if (i < t) begin
        if (grade_valid !== 1'b0 || gates_obs !== 3'b000) begin
          errors++; $display("FAIL settle_early: step %0d gv=%b gates=%b want 0/000", i, grade_valid, gates_obs);
        end
      end else begin
        exp_cnt[g] = (exp_cnt[g] < CMAX) ? exp_cnt[g] + 1 : CMAX;
        if (clr_on_inc) exp_cnt = '{0, 0, 0};
        exp_grade = g;
        if (grade_valid !== 1'b1 || grade !== g || gates_obs !== hot) begin
          errors++; $display("FAIL grade_latch: gv=%b grade=%b gates=%b want 1/%b/%b", grade_valid, grade, gates_obs, g, hot);
        end
        checks++;
        if (cnt_baja !== CW'(exp_cnt[0]) || cnt_media !== CW'(exp_cnt[1]) || cnt_alta !== CW'(exp_cnt[2])) begin
          errors++; $display("FAIL counts_latch: got %0d/%0d/%0d want %0d/%0d/%0d",
                             cnt_baja, cnt_media, cnt_alta, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
        end
      end
    end
    for (int gc = 1; gc < GATE; gc++) begin
      sens = 3'($urandom);
      tick();
      clear_counts = 1'b0;
      checks++;
      if (gates_obs !== hot || grade_valid !== 1'b0 || grade !== g) begin
        errors++; $display("FAIL gate_hold: cycle %0d gates=%b gv=%b grade=%b want %b/0/%b", gc, gates_obs, grade_valid, grade, hot, g);
      end
      if (gc == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gates_obs !== 3'b000 || feed_req !== 1'b0 || busy !== 1'b0 || grade_valid !== 1'b0) begin
          errors++; $display("FAIL async_reset: gates=%b feed_req=%b busy=%b want 000/0/0", gates_obs, feed_req, busy);
        end
        enable = 1'b0; bean_present = 1'b0;
        exp_cnt = '{0, 0, 0};
        exp_grade = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || fault !== 1'b0 || feed_req !== 1'b0 || grade !== 2'b00 || gates_obs !== 3'b000 ||
            cnt_baja !== '0 || cnt_media !== '0 || cnt_alta !== '0) begin
          errors++; $display("FAIL post_reset: busy=%b fault=%b feed_req=%b grade=%b gates=%b cnt=%0d/%0d/%0d want all 0",
                             busy, fault, feed_req, grade, gates_obs, cnt_baja, cnt_media, cnt_alta);
        end
        return;
      end
    end
    tick();
    checks++;
    if (gates_obs !== 3'b000 || busy !== 1'b1) begin
      errors++; $display("FAIL gate_close: gates=%b busy=%b want 000/1", gates_obs, busy);
    end
    repeat ($urandom_range(0, 3)) tick();
    bean_present = 1'b0;
    enable = end_enable;
    sens = 3'($urandom);
    tick();
    checks++;
    if (feed_req !== end_enable || busy !== end_enable || grade !== exp_grade || grade_valid !== 1'b0) begin
      errors++; $display("FAIL clear_exit: feed_req=%b busy=%b grade=%b gv=%b want %b/%b/%b/0",
                         feed_req, busy, grade, grade_valid, end_enable, end_enable, exp_grade);
    end
    checks++;
    if (cnt_baja !== CW'(exp_cnt[0]) || cnt_media !== CW'(exp_cnt[1]) || cnt_alta !== CW'(exp_cnt[2])) begin
      errors++; $display("FAIL counts_end: got %0d/%0d/%0d want %0d/%0d/%0d",
                         cnt_baja, cnt_media, cnt_alta, exp_cnt[0], exp_cnt[1], exp_cnt[2]);
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (feed_req !== 1'b0 || gates_obs !== 3'b000 || grade_valid !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 ||
        grade !== 2'b00 || cnt_baja !== '0 || cnt_media !== '0 || cnt_alta !== '0) begin
      errors++; $display("FAIL reset_values: feed_req=%b gates=%b gv=%b busy=%b fault=%b grade=%b want all 0",
                         feed_req, gates_obs, grade_valid, busy, fault, grade);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || feed_req !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b feed_req=%b want 0/0", busy, feed_req);
    end
  endtask

  task automatic test_feed_abort();
    enable = 1'b1;
    tick();
    checks++;
    if (feed_req !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL feed_start: feed_req=%b busy=%b want 1/1", feed_req, busy);
    end
    enable = 1'b0;
    tick();
    checks++;
    if (feed_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL feed_abort: feed_req=%b busy=%b want 0/0", feed_req, busy);
    end
  endtask

  task automatic test_alta();
    fill_const(3'b111);
    sort_bean(2, 3, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_glitch_media();
    seq = '{3'b110, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110};
    sort_bean(1, 0, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_baja_pair();
    fill_const(3'b011);
    sort_bean(0, 2, 1'b0, 1'b0, -1, 1'b1);
    fill_const(3'b101);
    sort_bean(3, 1, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_bean_drop();
    fill_const(3'b110);
    sort_bean(1, 2, 1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_timeout();
    enable = 1'b1;
    for (int k = 0; k < 4 && feed_req !== 1'b1; k++) tick();
    feed_ack = 1'b1;
    tick();
    feed_ack = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < int'(TOUT); i++) begin
      fault_clr = (i == 5);
      checks++;
      if (fault !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL timeout_early: cycle %0d fault=%b busy=%b want 0/1", i, fault, busy);
      end
      tick();
    end
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b1 || feed_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_fault: fault=%b feed_req=%b busy=%b want 1/0/0", fault, feed_req, busy);
    end
    enable = 1'b1;
    tick(); tick();
    checks++;
    if (fault !== 1'b1 || feed_req !== 1'b0) begin
      errors++; $display("FAIL fault_sticky: fault=%b feed_req=%b want 1/0", fault, feed_req);
    end
    enable = 1'b0;
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0 || feed_req !== 1'b0) begin
      errors++; $display("FAIL fault_clear: fault=%b busy=%b feed_req=%b want 0/0/0", fault, busy, feed_req);
    end
  endtask

  task automatic test_random(input int n);
    logic [2:0] v;
    for (int b = 0; b < n; b++) begin
      seq.delete();
      repeat ($urandom_range(0, 3)) begin
        v = 3'($urandom);
        repeat ($urandom_range(1, SETTLE - 1)) seq.push_back(v);
      end
      v = 3'($urandom);
      repeat (SETTLE) seq.push_back(v);
      sort_bean(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                1'b0, -1, 1'($urandom_range(0, 1)));
    end
    enable = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || feed_req !== 1'b0) begin
      errors++; $display("FAIL random_idle: busy=%b feed_req=%b want 0/0", busy, feed_req);
    end
  endtask

  task automatic test_saturation();
    fill_const(3'b111);
    for (int n = 0; n < 20 && exp_cnt[2] < CMAX; n++) sort_bean(0, 0, 1'b0, 1'b0, -1, 1'b0);
    sort_bean(1, 1, 1'b0, 1'b0, -1, 1'b0);
    sort_bean(1, 1, 1'b0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_reset_mid_actuate();
    fill_const(3'b111);
    sort_bean(1, 1, 1'b0, 1'b0, 2, 1'b0);
    fill_const(3'b110);
    sort_bean(2, 2, 1'b0, 1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_feed_abort();
    test_alta();
    test_glitch_media();
    test_baja_pair();
    test_bean_drop();
    test_timeout();
    test_random(30);
    test_saturation();
    test_reset_mid_actuate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
